soundweb_uart_tx: RTL and testbench

- Serialises one encoded Soundweb London packet of up to 29 bytes onto the RS-232 TX line toward the BSS device.
- Sits directly downstream of soundweb_encoder. Takes its flattened packet bytes plus a start pulse that the HPS issues through bss_ctl_1.
- Frames each byte as 8N1, sends bytes in index order, and stops after the ETX byte.
- Reports busy, done and a framing error back to the HPS through bss_ctl_0.

---
 rtl/soundweb_pkg.sv | 17 +
 rtl/uart_tx_byte.sv | 57 +++++
 rtl/soundweb_uart_tx.sv | 122 ++++++++++++
 tb/tb_soundweb_uart_tx.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soundweb_pkg.sv
// Constants and FSM state type shared by the Soundweb London encoder and UART transmitter.
package soundweb_pkg;

    localparam logic [7:0] STX = 8'h02;
    localparam logic [7:0] ETX = 8'h03;
    localparam int MAX_PACKET_BYTES = 29;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        START,
        DATA,
        STOP,
        FIN
    } tx_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: one start bit, eight data bits LSB first, one stop bit, DIV clocks per bit.
module uart_tx_byte #(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx,
    output logic       bit_end,
    output logic [3:0] frame_pos
);

    localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

    logic          active;
    logic [7:0]    shreg;
    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;

    // ready also rises in the final stop-bit cycle so the next byte starts with no idle gap.
    assign bit_end   = active && (baud_cnt == BAUD_LAST);
    assign ready     = !active || (bit_end && (bit_cnt == 4'd9));
    assign frame_pos = bit_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active   <= 1'b0;
            shreg    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
        end else if (valid && ready) begin
            active   <= 1'b1;
            shreg    <= data;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b0;
        end else if (active) begin
            if (baud_cnt == BAUD_LAST) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    active <= 1'b0;
                    tx     <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    tx      <= (bit_cnt == 4'd8) ? 1'b1 : shreg[bit_cnt[2:0]];
                end
            end else begin
                baud_cnt <= baud_cnt + BW'(1);
            end
        end
    end

endmodule

// File: rtl/soundweb_uart_tx.sv
// Sends one encoded Soundweb London packet (STX ... ETX) over an 8N1 UART line and reports status.
module soundweb_uart_tx
    import soundweb_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 115200,
    parameter int MAX_BYTES = MAX_PACKET_BYTES
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [8*MAX_BYTES-1:0] packet,
    input  logic                   start,
    output logic                   tx,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [4:0]             bytes_sent
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_BYTES - 1);

    tx_state_t              state;
    logic [8*MAX_BYTES-1:0] shadow;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       nxt_idx;
    logic [7:0]             cur_byte;
    logic [7:0]             byte_data;
    logic                   stx_ok;
    logic                   etx_hit;
    logic                   last_byte;
    logic                   byte_valid;
    logic                   ready;
    logic                   bit_end;
    logic [3:0]             frame_pos;

    // The next byte is offered during the last stop-bit cycle so frames run back to back.
    always_comb begin
        cur_byte   = shadow[8*idx +: 8];
        nxt_idx    = (idx == IDX_LAST) ? idx : idx + IDX_W'(1);
        stx_ok     = (shadow[7:0] == STX);
        etx_hit    = (cur_byte == ETX) && (idx != '0);
        last_byte  = etx_hit || (idx == IDX_LAST);
        byte_data  = (state == CHECK) ? shadow[7:0] : shadow[8*nxt_idx +: 8];
        byte_valid = ready && (((state == CHECK) && stx_ok) ||
                               ((state == STOP) && !last_byte));
    end

    uart_tx_byte #(
        .DIV(DIV)
    ) u_byte (
        .clk      (clk),
        .reset_n  (reset_n),
        .valid    (byte_valid),
        .data     (byte_data),
        .ready    (ready),
        .tx       (tx),
        .bit_end  (bit_end),
        .frame_pos(frame_pos)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shadow     <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            bytes_sent <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shadow     <= packet;
                        busy       <= 1'b1;
                        error      <= 1'b0;
                        bytes_sent <= '0;
                        idx        <= '0;
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    if (stx_ok) begin
                        state <= START;
                    end else begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                START: begin
                    if (bit_end) state <= DATA;
                end
                DATA: begin
                    if (bit_end && (frame_pos == 4'd8)) state <= STOP;
                end
                STOP: begin
                    if (ready) begin
                        bytes_sent <= bytes_sent + 5'd1;
                        if (last_byte) begin
                            error <= !etx_hit;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            idx   <= nxt_idx;
                            state <= START;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_soundweb_uart_tx.sv
// Testbench for soundweb_uart_tx: directed packets, a wire-decoding monitor and an expected-byte scoreboard.
module tb_soundweb_uart_tx;

    localparam int TB_CLK_HZ = 1000000;
    localparam int TB_BAUD   = 100000;
    localparam int TB_DIV    = 10;
    localparam int NB        = 29;
    localparam int DEF_DIV   = 434;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [8*NB-1:0] packet;
    logic            start;
    logic            tx;
    logic            busy;
    logic            done;
    logic            error;
    logic [4:0]      bytes_sent;

    logic [8*NB-1:0] def_packet;
    logic            def_start;
    logic            tx_def;
    logic            busy_def;
    logic            done_def;
    logic            error_def;
    logic [4:0]      bytes_sent_def;

    int cyc         = 0;
    int checks      = 0;
    int errors      = 0;
    int frames_seen = 0;
    int frames_base = 0;
    int done_pulses = 0;
    int start_cyc   = 0;
    logic [7:0] exp_q[$];

    soundweb_uart_tx #(
        .CLK_HZ   (TB_CLK_HZ),
        .BAUD     (TB_BAUD),
        .MAX_BYTES(NB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .packet    (packet),
        .start     (start),
        .tx        (tx),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .bytes_sent(bytes_sent)
    );

    soundweb_uart_tx dut_def (
        .clk       (clk),
        .reset_n   (reset_n),
        .packet    (def_packet),
        .start     (def_start),
        .tx        (tx_def),
        .busy      (busy_def),
        .done      (done_def),
        .error     (error_def),
        .bytes_sent(bytes_sent_def)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (done === 1'b1) done_pulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Decode every frame on tx, sampling mid-bit; a reset during a frame discards it.
    initial begin : wire_monitor
        logic [8:0] smp;
        logic [7:0] exp_byte;
        bit         ok;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && tx === 1'b0) begin
                ok  = 1'b1;
                smp = '0;
                for (int w = 0; w < TB_DIV / 2 && ok; w++) begin
                    @(negedge clk);
                    if (reset_n !== 1'b1) ok = 1'b0;
                end
                for (int i = 0; i < 9 && ok; i++) begin
                    for (int w = 0; w < TB_DIV && ok; w++) begin
                        @(negedge clk);
                        if (reset_n !== 1'b1) ok = 1'b0;
                    end
                    if (ok) smp[i] = tx;
                end
                if (ok) begin
                    frames_seen++;
                    checkOutput("frame expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        exp_byte = exp_q.pop_front();
                        checkOutput("wire byte", 32'(smp[7:0]), 32'(exp_byte));
                    end
                    checkOutput("stop bit", 32'(smp[8]), 1);
                end
            end
        end
    end

    // Entered at a negedge; with ignored=1 start is also held through the current done cycle.
    task automatic applyStimulus(input logic [8*NB-1:0] pkt, input int n_wire, input bit ignored);
        for (int k = 0; k < n_wire; k++) exp_q.push_back(pkt[8*k +: 8]);
        frames_base = frames_seen;
        packet = pkt;
        start  = 1'b1;
        if (ignored) begin
            @(negedge clk);
            checkOutput("start in done cycle ignored", 32'(busy), 0);
            checkOutput("error sticky until restart", 32'(error), 1);
        end
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic checkInFlight(input string tag);
        checkOutput({tag, " busy after accept"}, 32'(busy), 1);
        checkOutput({tag, " error cleared"}, 32'(error), 0);
        checkOutput({tag, " bytes_sent cleared"}, 32'(bytes_sent), 0);
        checkOutput({tag, " tx idle in check"}, 32'(tx), 1);
    endtask

    task automatic waitDone(input string tag, input int n, input bit exp_err, input int exp_bs,
                            input bit chk_low);
        int fl;
        bit seen;
        fl   = -1;
        seen = 1'b0;
        for (int k = 0; k < 10 * TB_DIV * (NB + 2); k++) begin
            if (tx === 1'b0 && fl < 0) fl = cyc;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput({tag, " done seen"}, 32'(seen), 1);
        checkOutput({tag, " done cycle"}, cyc, start_cyc + 2 + 10 * TB_DIV * n);
        if (chk_low) checkOutput({tag, " first low cycle"}, fl, (n > 0) ? start_cyc + 2 : -1);
        checkOutput({tag, " error"}, 32'(error), 32'(exp_err));
        checkOutput({tag, " bytes_sent"}, 32'(bytes_sent), exp_bs);
        checkOutput({tag, " frames"}, frames_seen - frames_base, n);
        checkOutput({tag, " scoreboard drained"}, exp_q.size(), 0);
    endtask

    task automatic checkAfterDone(input string tag);
        @(negedge clk);
        checkOutput({tag, " busy low after done"}, 32'(busy), 0);
        checkOutput({tag, " done one cycle"}, 32'(done), 0);
    endtask

    initial begin : stimulus
        logic [8*NB-1:0] pk;
        logic [8*NB-1:0] pmin;
        int d0;
        int s;
        bit seen;

        reset_n    = 1'b0;
        start      = 1'b0;
        packet     = '1;
        def_start  = 1'b0;
        def_packet = '1;
        repeat (3) @(negedge clk);
        checkOutput("reset tx", 32'(tx), 1);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset done", 32'(done), 0);
        checkOutput("reset error", 32'(error), 0);
        checkOutput("reset bytes_sent", 32'(bytes_sent), 0);
        reset_n = 1'b1;
        @(negedge clk);

        pmin = '1;
        pmin[7:0]   = 8'h02;
        pmin[15:8]  = 8'h8C;
        pmin[23:16] = 8'h00;
        pmin[31:24] = 8'h03;
        applyStimulus(pmin, 4, 1'b0);
        checkInFlight("min");
        waitDone("min", 4, 1'b0, 4, 1'b1);
        checkAfterDone("min");

        pk = '1;
        pk[7:0] = 8'h02;
        for (int k = 1; k < 28; k++) pk[8*k +: 8] = 8'h40 + 8'(k);
        pk[8*28 +: 8] = 8'h03;
        applyStimulus(pk, 29, 1'b0);
        checkInFlight("full");
        waitDone("full", 29, 1'b0, 29, 1'b1);
        checkAfterDone("full");

        pk = '1;
        pk[7:0] = 8'h02;
        for (int k = 1; k < 29; k++) pk[8*k +: 8] = 8'h55;
        applyStimulus(pk, 29, 1'b0);
        checkInFlight("noetx");
        waitDone("noetx", 29, 1'b1, 29, 1'b1);
        checkAfterDone("noetx");

        pk = '1;
        pk[7:0] = 8'h7F;
        applyStimulus(pk, 0, 1'b0);
        checkInFlight("badhdr");
        waitDone("badhdr", 0, 1'b1, 0, 1'b1);
        applyStimulus(pmin, 4, 1'b1);
        checkInFlight("retry");
        waitDone("retry", 4, 1'b0, 4, 1'b1);
        checkAfterDone("retry");

        pk = '1;
        pk[7:0]   = 8'h02;
        pk[15:8]  = 8'h11;
        pk[23:16] = 8'h22;
        pk[31:24] = 8'h33;
        pk[39:32] = 8'h03;
        applyStimulus(pk, 5, 1'b0);
        checkInFlight("busy");
        d0 = done_pulses;
        repeat (150) @(negedge clk);
        pk = '1;
        pk[7:0]   = 8'h02;
        pk[15:8]  = 8'h99;
        pk[23:16] = 8'h03;
        packet = pk;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("busy", 5, 1'b0, 5, 1'b0);
        checkAfterDone("busy");
        repeat (20) @(negedge clk);
        checkOutput("busy single done", done_pulses - d0, 1);

        pk = '1;
        pk[7:0]   = 8'h02;
        pk[15:8]  = 8'hF0;
        pk[23:16] = 8'h03;
        applyStimulus(pk, 3, 1'b0);
        checkInFlight("rst");
        for (int k = 0; k < 300 && cyc < start_cyc + 147; k++) @(negedge clk);
        checkOutput("rst tx before reset", 32'(tx), 0);
        checkOutput("rst busy before reset", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        checkOutput("rst tx forced high", 32'(tx), 1);
        checkOutput("rst busy cleared", 32'(busy), 0);
        checkOutput("rst bytes_sent cleared", 32'(bytes_sent), 0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rst tx idle after release", 32'(tx), 1);
        applyStimulus(pmin, 4, 1'b0);
        checkInFlight("post-rst");
        waitDone("post-rst", 4, 1'b0, 4, 1'b1);
        checkAfterDone("post-rst");

        pk = '1;
        pk[7:0]  = 8'h02;
        pk[15:8] = 8'h03;
        def_packet = pk;
        def_start  = 1'b1;
        s = cyc;
        @(negedge clk);
        def_start = 1'b0;
        checkOutput("def busy", 32'(busy_def), 1);
        seen = 1'b0;
        for (int k = 0; k < 25 * DEF_DIV; k++) begin
            if (done_def === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("def done seen", 32'(seen), 1);
        checkOutput("def done cycle", cyc, s + 2 + 20 * DEF_DIV);
        checkOutput("def error", 32'(error_def), 0);
        checkOutput("def bytes_sent", 32'(bytes_sent_def), 2);
        checkOutput("def tx idle", 32'(tx_def), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
